// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the trigger capture block.
// Holds the capture FSM state encoding, the trigger edge encodings, the
// sample width and the trigger-condition helper used by the top level.
package trigger_capture_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  // Level crossing between the previous stored sample and the current one.
  // All comparisons are unsigned, which matches offset-binary samples.
  function automatic logic trig_cond(
    input logic [SAMPLE_W-1:0] prev,
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] level,
    input logic                edge_sel
  );
    if (edge_sel == EDGE_FALLING)
      return (prev > level) && (cur <= level);
    else
      return (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// Sample stream and readout bus of the trigger capture block.
//   sample / sample_valid : incoming offset-binary samples (master -> slave)
//   rd_en / rd_addr       : readout request, logical index (master -> slave)
//   rd_data / rd_valid    : readout result, one cycle after rd_en (slave -> master)
// DEPTH must match the DEPTH of the trigger_capture instance on this bus.
interface trigger_capture_if #(
  parameter int DEPTH = 256
);
  import trigger_capture_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;

  modport master (
    output sample, sample_valid, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sample, sample_valid, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/capture_ram.sv
// Capture buffer: simple dual-port RAM, one write port and one registered
// read port with one cycle of latency. No reset on the array or the read
// register so it maps onto block RAM.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates only when re is high
//   rdata        : registered read data
module capture_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/trigger_capture.sv
// Oscilloscope-style trigger capture. After arm, samples are written into a
// circular buffer; PRE_TRIG samples are collected before a trigger is
// accepted, then DEPTH-PRE_TRIG samples (trigger sample included) are
// stored and the block parks in DONE for readout by logical index, where
// index PRE_TRIG is the trigger sample.
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : sample stream in, readout request/result
//   arm                   : restart a capture (wins over force_trig)
//   force_trig            : force a trigger while waiting for one
//   trig_level, trig_edge : threshold and edge (0 rising, 1 falling)
//   busy                  : capture in progress (PRE, WAIT_TRIG, POST)
//   done                  : capture complete, readout allowed
// DEPTH must be a power of two; 1 <= PRE_TRIG <= DEPTH-1.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  trigger_capture_if.slave    bus,
  input  logic                arm,
  input  logic                force_trig,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_edge,
  output logic                busy,
  output logic                done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 1);

  state_t state, state_nxt;

  logic [AW-1:0]       wptr, tptr, pre_cnt, post_cnt, raddr;
  logic [SAMPLE_W-1:0] prev, ram_q;
  logic                prev_valid, capturing, wr_en, trig, rd_ok;
  logic                rd_valid_q, rd_seen;

  // The arm cycle itself is a restart, so nothing is written in it; this
  // keeps the pre count and the prev flag consistent with the buffer.
  always_comb begin
    capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    wr_en     = capturing && bus.sample_valid && !arm;
    trig      = (state == WAIT_TRIG) && !arm &&
                (force_trig ||
                 (bus.sample_valid && prev_valid &&
                  trig_cond(prev, bus.sample, trig_level, trig_edge)));
    rd_ok     = (state == DONE) && bus.rd_en && !arm;
    raddr     = tptr - PRE_OFF + bus.rd_addr;
    busy      = capturing;
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A trigger carried by a valid sample already stores one post sample,
  // so with a single-sample post window it goes straight to DONE.
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = PRE;
    end else begin
      case (state)
        PRE:       if (wr_en && pre_cnt == PRE_LAST) state_nxt = WAIT_TRIG;
        WAIT_TRIG: if (trig) state_nxt = (wr_en && POST_LAST == '0) ? DONE : POST;
        POST:      if (wr_en && post_cnt == POST_LAST) state_nxt = DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  // Write pointer, counters, previous sample and trigger pointer. A forced
  // trigger without a sample latches wptr, which is where the next stored
  // sample lands, so it still sits at logical index PRE_TRIG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      tptr       <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (arm) begin
      pre_cnt    <= '0;
      post_cnt   <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr       <= wptr + AW'(1);
        prev       <= bus.sample;
        prev_valid <= 1'b1;
      end
      if (state == PRE && wr_en)
        pre_cnt <= pre_cnt + AW'(1);
      if (trig) begin
        tptr     <= wptr;
        post_cnt <= wr_en ? AW'(1) : '0;
      end else if (state == POST && wr_en) begin
        post_cnt <= post_cnt + AW'(1);
      end
    end
  end

  // rd_seen masks the unreset RAM read register until the first real read,
  // giving rd_data a defined zero after reset without touching the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_seen    <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok)
        rd_seen <= 1'b1;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_seen ? ram_q : '0;

  capture_ram #(
    .DEPTH(DEPTH),
    .WIDTH(SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr),
    .wdata(bus.sample),
    .re   (rd_ok),
    .raddr(raddr),
    .rdata(ram_q)
  );

endmodule
